snare_sample_writer: RTL



---
 rtl/snare_pkg.sv | 15 +
 rtl/sample_threshold_detect.sv | 22 ++
 rtl/snare_sample_writer.sv | 113 +++++++++++
 3 files changed

// File: rtl/snare_pkg.sv
// Constants shared by the snare sample writer and the snare playback counter.
// Both blocks must agree on the RAM address width and on the last valid address.
package snare_pkg;

    localparam int unsigned SNARE_ADDR_W   = 15;
    localparam int unsigned SNARE_MAX_ADDR = 16481;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_RECORD = 2'd2,
        S_DONE   = 2'd3
    } snare_state_e;

endpackage

// File: rtl/sample_threshold_detect.sv
// Combinational trigger: asserts when the magnitude of a signed sample reaches THRESHOLD.
// The magnitude is one bit wider than the sample, so the most negative value cannot overflow.
module sample_threshold_detect #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned THRESHOLD = 512
) (
    input  logic [DATA_W-1:0] sample_data_i,
    output logic              trigger_o
);

    localparam logic [DATA_W:0] ThreshW = (DATA_W + 1)'(THRESHOLD);

    logic [DATA_W:0] ext;
    logic [DATA_W:0] mag;

    always_comb begin
        ext       = {sample_data_i[DATA_W-1], sample_data_i};
        mag       = ext[DATA_W] ? (~ext + (DATA_W + 1)'(1)) : ext;
        trigger_o = (mag >= ThreshW);
    end

endmodule

// File: rtl/snare_sample_writer.sv
// Records a codec stream into the snare sample RAM once the level crosses a threshold,
// and reports how many samples were written so playback stops at the true end.
module snare_sample_writer
    import snare_pkg::*;
#(
    parameter int unsigned ADDR_W    = SNARE_ADDR_W,
    parameter int unsigned MAX_ADDR  = SNARE_MAX_ADDR,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned THRESHOLD = 512
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              sample_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MAX_ADDR);

    snare_state_e      state_q, state_d;
    logic [ADDR_W-1:0] length_q, length_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              trigger;
    logic              accept;

    sample_threshold_detect #(
        .DATA_W    (DATA_W),
        .THRESHOLD (THRESHOLD)
    ) u_detect (
        .sample_data_i (sample_data),
        .trigger_o     (trigger)
    );

    assign sample_ready = (state_q == S_ARM) || (state_q == S_RECORD);
    assign accept       = sample_valid && sample_ready;

    always_comb begin
        state_d   = state_q;
        length_d  = length_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_ARM;
                    length_d = '0;
                end
            end
            S_ARM: begin
                // Abort takes precedence, so a sample accepted alongside it is dropped.
                if (abort) begin
                    state_d = S_DONE;
                end else if (accept && trigger) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = sample_data;
                    length_d  = ADDR_W'(1);
                    state_d   = (LastAddr == '0) ? S_DONE : S_RECORD;
                end
            end
            S_RECORD: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = length_q;
                    wr_data_d = sample_data;
                    length_d  = length_q + ADDR_W'(1);
                    if (length_q == LastAddr) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            length_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            length_q  <= length_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign length  = length_q;
    assign busy    = (state_q == S_ARM) || (state_q == S_RECORD);
    assign done    = (state_q == S_DONE);

endmodule
